// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit function codes and RV32I opcodes.
// Used by the issue stage, its decoder and the ALU itself.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational RV32I integer-compute decoder (OP, OP-IMM, LUI, AUIPC).
// Ports: inst/pc/rs1_data/rs2_data in; a, b, func, rd, reg_we, illegal out.
module rv32_alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  func,
    output logic [4:0]  rd,
    output logic        reg_we,
    output logic        illegal
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic [3:0]  func_d;
    logic [3:0]  f3_func;
    logic        bad;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_u = {inst[31:12], 12'b0};
    assign shamt = {27'b0, inst[24:20]};

    // Base function selected by funct3 alone (f7=00 variants).
    always_comb begin
        f3_func = ALU_ADD;
        case (f3)
            3'b000:  f3_func = ALU_ADD;
            3'b001:  f3_func = ALU_SLL;
            3'b010:  f3_func = ALU_SLT;
            3'b011:  f3_func = ALU_SLTU;
            3'b100:  f3_func = ALU_XOR;
            3'b101:  f3_func = ALU_SRL;
            3'b110:  f3_func = ALU_OR;
            default: f3_func = ALU_AND;
        endcase
    end

    always_comb begin
        a_d    = '0;
        b_d    = '0;
        func_d = ALU_ADD;
        bad    = 1'b0;
        case (opc)
            OPC_OP: begin
                a_d = rs1_data;
                b_d = rs2_data;
                if (f7 == F7_BASE) begin
                    func_d = f3_func;
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    func_d = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    func_d = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                a_d    = rs1_data;
                b_d    = imm_i;
                func_d = f3_func;
                // Shift immediates carry f7 in imm[11:5] and use only shamt.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    b_d = shamt;
                    if (f7 == F7_ALT && f3 == 3'b101) begin
                        func_d = ALU_SRA;
                    end else if (f7 != F7_BASE) begin
                        bad = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                b_d = imm_u;
            end
            OPC_AUIPC: begin
                a_d = pc;
                b_d = imm_u;
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal entries present a harmless zeroed ALU op with no writeback.
    assign a       = bad ? '0 : a_d;
    assign b       = bad ? '0 : b_d;
    assign func    = bad ? ALU_ADD : func_d;
    assign rd      = inst[11:7];
    assign reg_we  = !bad && (inst[11:7] != 5'd0);
    assign illegal = bad;

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes one instruction and holds it in a single-entry
// register with valid/ready handshake, stall and flush toward the ALU.
// Ports: clk, reset, in_valid/in_ready, inst, pc, rs1_data, rs2_data, flush,
// out_valid/out_ready, alu_a, alu_b, alu_func, rd, reg_we, illegal, pc_out.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_func,
    output logic [4:0]      rd,
    output logic            reg_we,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("alu_issue: only XLEN=32 is supported");
    end

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_func;
    logic [4:0]  dec_rd;
    logic        dec_we;
    logic        dec_bad;
    logic        accept;

    rv32_alu_decode u_dec (
        .inst     (inst),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .a        (dec_a),
        .b        (dec_b),
        .func     (dec_func),
        .rd       (dec_rd),
        .reg_we   (dec_we),
        .illegal  (dec_bad)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_func  <= ALU_ADD;
            rd        <= '0;
            reg_we    <= 1'b0;
            illegal   <= 1'b0;
            pc_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_a     <= dec_a;
            alu_b     <= dec_b;
            alu_func  <= dec_func;
            rd        <= dec_rd;
            reg_we    <= dec_we;
            illegal   <= dec_bad;
            pc_out    <= pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
